edge_detector: RTL and testbench
================================

EDGE_DETECTOR -- requirements
Module: edge_detector

Interface
REQ-001 Parameter BITS_ADC, default 8, sample and threshold width in bits.
REQ-002 Parameter RISING, default 1; 1 selects rising-edge detection, 0 selects falling-edge detection.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 trigger_value  input  BITS_ADC  unsigned threshold compared against samples.
REQ-006 input_sample  input  BITS_ADC  unsigned ADC sample, valid only when input_rdy=1.
REQ-007 input_rdy  input  1  single-cycle qualifier; the sample is consumed on each cycle it is high.
REQ-008 triggered  output  1  registered trigger flag.

Function
REQ-009 Internal state SHALL be limited to: prev_sample (BITS_ADC bits), prev_valid (1 bit) and the triggered register.
REQ-010 On a cycle with input_rdy=0, all state SHALL hold.
REQ-011 On a cycle with input_rdy=1:
- prev_sample <= input_sample.
- prev_valid <= 1.
REQ-012 Rising crossing (RISING=1): prev_valid=1, prev_sample < trigger_value and input_sample >= trigger_value; all comparisons unsigned, full BITS_ADC width.
REQ-013 Falling crossing (RISING=0): prev_valid=1, prev_sample > trigger_value and input_sample <= trigger_value.
REQ-014 A crossing evaluated on an input_rdy=1 cycle SHALL set triggered=1 on the next clock edge (latency 1 cycle).
REQ-015 No combinational path from any input to triggered.
REQ-016 The first sample after reset (prev_valid=0) SHALL only load history and SHALL never trigger.
REQ-017 triggered SHALL be sticky: once set, it stays 1 until rst, regardless of further samples.
REQ-018 trigger_value SHALL be sampled as presented on the same cycle as the sample; a changing threshold affects only later comparisons.
REQ-019 Equal consecutive samples (no change) SHALL never trigger.
REQ-020 Boundary conditions:
- A sample exactly equal to trigger_value after a lower sample triggers (rising).
- trigger_value=0 can never produce a rising trigger.
- trigger_value=2^BITS_ADC-1 triggers only when a sample equals that value.

Reset
REQ-021 rst=1 at a clock edge SHALL clear triggered, prev_valid and prev_sample to 0, overriding input_rdy on that cycle.
REQ-022 Reset SHALL take effect mid-operation; the upstream controller holds rst high outside its trigger-search state, and detection restarts cleanly after release.
REQ-023 All registers SHALL power up at 0.

Structure
REQ-024 No shared package; the block has no typedefs and no constants beyond its two parameters.
REQ-025 The block SHALL be a single module with no sub-modules.
REQ-026 Comparators and next-state logic SHALL be combinational; flops SHALL be confined to one clocked process.

Verification
REQ-027 Rising trigger. Stimulus: RISING=1, trigger_value=0x80, rst released, samples 0x10, 0x7F, 0x80 (each with input_rdy=1). Response: triggered=0 through the 0x7F sample; triggered=1 one cycle after the 0x80 sample.
REQ-028 First sample ignored. Stimulus: after reset, first sample 0xFF with trigger_value=0x80. Response: triggered stays 0; a following 0x00, 0x90 sequence sets triggered=1.
REQ-029 input_rdy gating. Stimulus: sample 0x10 with input_rdy=1, then 0x90 held with input_rdy=0 for 5 cycles. Response: triggered=0 throughout; triggered=1 only after 0x90 is presented with input_rdy=1.
REQ-030 Falling trigger and sticky flag. Stimulus: RISING=0, trigger_value=0x40, samples 0x50, 0x40, then 0x60, 0x70. Response: triggered=1 one cycle after the 0x40 sample and remains 1.
REQ-031 Reset mid-operation. Stimulus: assert rst for 1 cycle while triggered=1, release, then sample 0x90 with trigger_value=0x80. Response: triggered=0 the cycle after rst, and stays 0 because the 0x90 sample is the first after reset.
REQ-032 No change, no trigger. Stimulus: 0x80 repeated 10 times with trigger_value=0x80. Response: triggered=0 throughout.

Source files
------------

// File: rtl/edge_detector.sv
// Threshold-crossing trigger for an ADC sample stream.
// The triggered flag is registered and sticky until reset.
module edge_detector #(
    parameter int BITS_ADC = 8,
    parameter int RISING   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITS_ADC-1:0] trigger_value,
    input  logic [BITS_ADC-1:0] input_sample,
    input  logic                input_rdy,
    output logic                triggered
);

    // Registers start at zero at power-up, matching the reset state.
    logic [BITS_ADC-1:0] prev_sample_q = '0;
    logic                prev_valid_q  = 1'b0;
    logic                triggered_q   = 1'b0;

    logic [BITS_ADC-1:0] prev_sample_d;
    logic                prev_valid_d;
    logic                triggered_d;
    logic                crossing;

    // The comparison uses the threshold presented alongside the current sample.
    always_comb begin
        crossing = 1'b0;
        if (RISING != 0) begin
            crossing = (prev_sample_q < trigger_value) && (input_sample >= trigger_value);
        end else begin
            crossing = (prev_sample_q > trigger_value) && (input_sample <= trigger_value);
        end
    end

    always_comb begin
        prev_sample_d = prev_sample_q;
        prev_valid_d  = prev_valid_q;
        triggered_d   = triggered_q;
        if (input_rdy) begin
            prev_sample_d = input_sample;
            prev_valid_d  = 1'b1;
            if (prev_valid_q && crossing) begin
                triggered_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sample_q <= '0;
            prev_valid_q  <= 1'b0;
            triggered_q   <= 1'b0;
        end else begin
            prev_sample_q <= prev_sample_d;
            prev_valid_q  <= prev_valid_d;
            triggered_q   <= triggered_d;
        end
    end

    assign triggered = triggered_q;

endmodule

// File: tb/tb_edge_detector.sv
// Directed bench for edge_detector: a rising and a falling instance share one
// stimulus stream, and each scenario checks the expected flag values inline.
module tb_edge_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] triggerValue = 8'h00;
    logic [7:0] inputSample  = 8'h00;
    logic       inputRdy     = 1'b0;
    logic       trigRise;
    logic       trigFall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    edge_detector #(.BITS_ADC(8), .RISING(1)) dutRise (
        .clk          (clk),
        .rst          (rst),
        .trigger_value(triggerValue),
        .input_sample (inputSample),
        .input_rdy    (inputRdy),
        .triggered    (trigRise)
    );

    edge_detector #(.BITS_ADC(8), .RISING(0)) dutFall (
        .clk          (clk),
        .rst          (rst),
        .trigger_value(triggerValue),
        .input_sample (inputSample),
        .input_rdy    (inputRdy),
        .triggered    (trigFall)
    );

    // Drives one cycle of inputs on the falling edge, then returns just after
    // the rising edge that consumed them.
    task automatic applyStimulus(input logic r, input logic rdy,
                                 input logic [7:0] smp, input logic [7:0] thr);
        @(negedge clk);
        rst          = r;
        inputRdy     = rdy;
        inputSample  = smp;
        triggerValue = thr;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (trigRise !== 1'b0) begin
            $display("[TB] FAIL reset_rise: got %b expected 0", trigRise); failures++;
        end
        checks++;
        if (trigFall !== 1'b0) begin
            $display("[TB] FAIL reset_fall: got %b expected 0", trigFall); failures++;
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h80);
    endtask

    task automatic test_rising();
        logic [7:0] smp [3] = '{8'h10, 8'h7F, 8'h80};
        logic       expR [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, smp[i], 8'h80);
            checks++;
            if (trigRise !== expR[i]) begin
                $display("[TB] FAIL rising_step%0d: got %b expected %b", i, trigRise, expR[i]); failures++;
            end
            checks++;
            if (trigFall !== 1'b0) begin
                $display("[TB] FAIL rising_fallinst_step%0d: got %b expected 0", i, trigFall); failures++;
            end
        end
    endtask

    task automatic test_first_sample();
        logic [7:0] smp [3] = '{8'hFF, 8'h00, 8'h90};
        logic       expR [3] = '{1'b0, 1'b0, 1'b1};
        logic       expF [3] = '{1'b0, 1'b1, 1'b1};
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, smp[i], 8'h80);
            checks++;
            if (trigRise !== expR[i]) begin
                $display("[TB] FAIL first_sample_rise%0d: got %b expected %b", i, trigRise, expR[i]); failures++;
            end
            checks++;
            if (trigFall !== expF[i]) begin
                $display("[TB] FAIL first_sample_fall%0d: got %b expected %b", i, trigFall, expF[i]); failures++;
            end
        end
    endtask

    task automatic test_rdy_gating();
        doReset();
        applyStimulus(1'b0, 1'b1, 8'h10, 8'h80);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h90, 8'h80);
            checks++;
            if (trigRise !== 1'b0) begin
                $display("[TB] FAIL rdy_gating_hold%0d: got %b expected 0", i, trigRise); failures++;
            end
        end
        applyStimulus(1'b0, 1'b1, 8'h90, 8'h80);
        checks++;
        if (trigRise !== 1'b1) begin
            $display("[TB] FAIL rdy_gating_fire: got %b expected 1", trigRise); failures++;
        end
    endtask

    task automatic test_falling_sticky();
        logic [7:0] smp [4] = '{8'h50, 8'h40, 8'h60, 8'h70};
        logic       expF [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, smp[i], 8'h40);
            checks++;
            if (trigFall !== expF[i]) begin
                $display("[TB] FAIL falling_step%0d: got %b expected %b", i, trigFall, expF[i]); failures++;
            end
            checks++;
            if (trigRise !== 1'b0) begin
                $display("[TB] FAIL falling_riseinst_step%0d: got %b expected 0", i, trigRise); failures++;
            end
        end
    endtask

    task automatic test_reset_mid_op();
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h80);
        checks++;
        if (trigFall !== 1'b0) begin
            $display("[TB] FAIL midreset_clear: got %b expected 0", trigFall); failures++;
        end
        applyStimulus(1'b0, 1'b1, 8'h90, 8'h80);
        checks++;
        if (trigRise !== 1'b0) begin
            $display("[TB] FAIL midreset_first_rise: got %b expected 0", trigRise); failures++;
        end
        checks++;
        if (trigFall !== 1'b0) begin
            $display("[TB] FAIL midreset_first_fall: got %b expected 0", trigFall); failures++;
        end
    endtask

    task automatic test_reset_overrides_rdy();
        doReset();
        applyStimulus(1'b0, 1'b1, 8'h10, 8'h80);
        applyStimulus(1'b1, 1'b1, 8'h10, 8'h80);
        applyStimulus(1'b0, 1'b1, 8'h90, 8'h80);
        checks++;
        if (trigRise !== 1'b0) begin
            $display("[TB] FAIL reset_overrides_rdy: got %b expected 0", trigRise); failures++;
        end
    endtask

    task automatic test_no_change();
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h80, 8'h80);
            checks++;
            if (trigRise !== 1'b0 || trigFall !== 1'b0) begin
                $display("[TB] FAIL no_change%0d: got rise=%b fall=%b expected 0/0", i, trigRise, trigFall); failures++;
            end
        end
    endtask

    task automatic test_threshold_zero();
        logic [7:0] smp [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        logic       expF [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, smp[i], 8'h00);
            checks++;
            if (trigRise !== 1'b0) begin
                $display("[TB] FAIL thr_zero_rise%0d: got %b expected 0", i, trigRise); failures++;
            end
            checks++;
            if (trigFall !== expF[i]) begin
                $display("[TB] FAIL thr_zero_fall%0d: got %b expected %b", i, trigFall, expF[i]); failures++;
            end
        end
    endtask

    task automatic test_threshold_max();
        logic [7:0] smp [3] = '{8'h00, 8'hFE, 8'hFF};
        logic       expR [3] = '{1'b0, 1'b0, 1'b1};
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, smp[i], 8'hFF);
            checks++;
            if (trigRise !== expR[i]) begin
                $display("[TB] FAIL thr_max_rise%0d: got %b expected %b", i, trigRise, expR[i]); failures++;
            end
        end
    endtask

    task automatic test_threshold_change();
        doReset();
        applyStimulus(1'b0, 1'b1, 8'h10, 8'h80);
        applyStimulus(1'b0, 1'b1, 8'h50, 8'h40);
        checks++;
        if (trigRise !== 1'b1) begin
            $display("[TB] FAIL thr_change_same_cycle: got %b expected 1", trigRise); failures++;
        end
        doReset();
        applyStimulus(1'b0, 1'b1, 8'h10, 8'h40);
        applyStimulus(1'b0, 1'b1, 8'h50, 8'h80);
        checks++;
        if (trigRise !== 1'b0) begin
            $display("[TB] FAIL thr_change_raised: got %b expected 0", trigRise); failures++;
        end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_first_sample();
        test_rdy_gating();
        test_falling_sticky();
        test_reset_mid_op();
        test_reset_overrides_rdy();
        test_no_change();
        test_threshold_zero();
        test_threshold_max();
        test_threshold_change();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
